dmem_ctrl: RTL and testbench

Initiator side of the single-port word RAM interface: combinational read on address, write committed at posedge when write-enable is high. It accepts byte-addressed load/store requests from the core over a valid/ready handshake and handles byte lanes, alignment and bounds. It drives the RAM word address, write data and write enable, and returns load data or store acknowledgement over a valid/ready response channel. Sub-word stores use a single-cycle read-modify-write on the RAM's combinational read port.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_align.sv | 38 +++
 rtl/dmem_ctrl.sv | 117 +++++++++++
 tb/tb_dmem_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory initiator.
// Sizes follow the request encoding; byte_mask gives the lanes touched by an access.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  function automatic logic [3:0] byte_mask(input size_t size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Little-endian lane handling: merges store data into the old word and
// extracts/extends load data from the addressed lanes.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  size_t       size,
  input  logic [1:0]  offset,
  input  logic        sign,
  output logic [31:0] new_word,
  output logic [31:0] load_data
);

  logic [3:0]  mask;
  logic [31:0] wshift;
  logic [31:0] rshift;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    mask     = byte_mask(size, offset);
    wshift   = wdata << {offset, 3'b000};
    rshift   = old_word >> {offset, 3'b000};
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) new_word[8*i +: 8] = wshift[8*i +: 8];
    end

    case (size)
      SZ_BYTE: load_data = {{24{sign & rshift[7]}},  rshift[7:0]};
      SZ_HALF: load_data = {{16{sign & rshift[15]}}, rshift[15:0]};
      SZ_WORD: load_data = old_word;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed load/store initiator for a single-port word RAM with a
// combinational read port; one request in flight, IDLE -> ACCESS -> RESP.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_DEPTH = 4096
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_SIGNED,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [31:0]           REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [31:0]           RSP_RDATA,
  output logic                  RSP_ERR,
  output logic [ADDR_WIDTH-1:0] MEM_A,
  output logic [31:0]           MEM_WD,
  output logic                  MEM_WE,
  input  logic [31:0]           MEM_RD
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  size_t                 size_q;
  logic                  signed_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [ADDR_WIDTH-3:0] word_idx;
  logic                  acc_err;
  logic [31:0]           merged;
  logic [31:0]           extracted;

  assign word_idx = addr_q[ADDR_WIDTH-1:2];
  assign MEM_A    = {2'b00, word_idx};

  always_comb begin
    acc_err = (size_q == SZ_ILL)
           || (size_q == SZ_HALF && addr_q[0])
           || (size_q == SZ_WORD && addr_q[1:0] != 2'b00)
           || (64'(word_idx) >= 64'(DATA_DEPTH));
  end

  dmem_align u_align (
    .old_word  (MEM_RD),
    .wdata     (wdata_q),
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .sign      (signed_q),
    .new_word  (merged),
    .load_data (extracted)
  );

  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    MEM_WE    = 1'b0;
    case (state)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_nxt = ACCESS;
      end
      ACCESS: begin
        MEM_WE    = we_q && !acc_err;
        state_nxt = RESP;
      end
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outside a committed store the write port just shows the registered data.
    MEM_WD = MEM_WE ? merged : wdata_q;
  end

  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && REQ_VALID) begin
        addr_q   <= REQ_ADDR;
        we_q     <= REQ_WE;
        size_q   <= size_t'(REQ_SIZE);
        signed_q <= REQ_SIGNED;
        wdata_q  <= REQ_WDATA;
      end
      if (state == ACCESS) begin
        rdata_q <= (we_q || acc_err) ? 32'h0 : extracted;
        err_q   <= acc_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: behavioural RAM plus a byte-level
// reference model, directed scenarios and randomized load/store traffic.
module tb_dmem_ctrl;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  dmem_ctrl #(.ADDR_WIDTH(32), .DATA_DEPTH(DEPTH)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_SIZE(req_size), .REQ_SIGNED(req_signed), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
    .RSP_ERR(rsp_err),
    .MEM_A(mem_a), .MEM_WD(mem_wd), .MEM_WE(mem_we), .MEM_RD(mem_rd)
  );

  always #5 clk = ~clk;

  // Attached RAM: combinational read, write at posedge.
  logic [31:0] ram [DEPTH];
  assign mem_rd = (mem_a < DEPTH) ? ram[mem_a[11:0]] : 32'h0;
  always @(posedge clk) if (mem_we) ram[mem_a[11:0]] <= mem_wd;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic [31:0] ref_mem [DEPTH];
  exp_t        exp_q [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          we_cyc = -1;
  logic [31:0] exp_wd, exp_ma;
  bit          busy = 0;
  bit          chk_en = 0;
  int          ready_mode = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: byte-granular arithmetic over the addressed word.
  function automatic void model(input logic [31:0] a, input logic w, input logic [1:0] sz,
                                input logic sg, input logic [31:0] wd, input logic [31:0] old,
                                output logic e, output logic [31:0] rd, output logic [31:0] nw);
    int     nb, off;
    longint field;
    off = int'(a % 4);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e   = (sz == 2'd3) || (off % nb != 0) || ((a / 4) >= DEPTH);
    rd  = 32'h0;
    nw  = old;
    if (!e && !w) begin
      field = (longint'(old) >> (8 * off)) % (longint'(1) << (8 * nb));
      if (sg && nb < 4 && field >= (longint'(1) << (8 * nb - 1)))
        field = field - (longint'(1) << (8 * nb));
      rd = field[31:0];
    end
    if (!e && w)
      for (int i = 0; i < nb; i++) nw[8*(off+i) +: 8] = wd[8*i +: 8];
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom % 3 != 0);
      default: rsp_ready = 1'b0;
    endcase
  end

  // Compare process: every cycle, outputs against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", {31'b0, req_ready}, {31'b0, !busy});
      check("mem_we", {31'b0, mem_we}, {31'b0, busy && cyc == we_cyc});
      if (mem_we) begin
        check("mem_a", mem_a, exp_ma);
        check("mem_wd", mem_wd, exp_wd);
      end
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, busy && cyc > acc_cyc});
      if (rsp_valid && exp_q.size() > 0) begin
        check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_q[0].err});
        if (rsp_ready) begin
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
          void'(exp_q.pop_front());
          busy = 0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd, input bit abort = 0);
    int          n = 0;
    logic        e;
    logic [31:0] rd, nw, old;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_ready", {31'b0, req_ready}, 32'h1);
      return;
    end
    if (abort) chk_en = 0;
    req_valid = 1'b1; req_addr = a; req_we = w; req_size = sz;
    req_signed = sg; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
    we_cyc  = -1;
    if (!abort) begin
      old = ((a / 4) < DEPTH) ? ref_mem[a[13:2]] : 32'h0;
      model(a, w, sz, sg, wd, old, e, rd, nw);
      exp_q.push_back('{err: e, rdata: rd});
      busy = 1;
      if (w && !e) begin
        ref_mem[a[13:2]] = nw;
        we_cyc = acc_cyc;
        exp_wd = nw;
        exp_ma = a >> 2;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", {31'b0, busy}, 32'h0);
  endtask

  task automatic run(input logic [31:0] a, input logic w, input logic [1:0] sz,
                     input logic sg, input logic [31:0] wd);
    issue(a, w, sz, sg, wd);
    drain();
  endtask

  initial begin
    int          acc[4];
    logic [31:0] v0;
    logic        e0;
    int          n;
    int          bad;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i] <= 32'h0;
      ref_mem[i] = 32'h0;
    end

    #3;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    #19;
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk_en = 1;

    // Word store/load round trip.
    run(32'h100, 1, 2'b10, 0, 32'hDEADBEEF);
    run(32'h100, 0, 2'b10, 0, 32'h0);
    check("word_load", last_rdata, 32'hDEADBEEF);

    // Sub-word stores and extended loads.
    run(32'h100, 1, 2'b10, 0, 32'h11223344);
    run(32'h101, 1, 2'b00, 0, 32'h000000A5);
    check("byte_store_ram", ram[12'h40], 32'h1122A544);
    run(32'h101, 0, 2'b00, 1, 32'h0);
    check("sbyte_load", last_rdata, 32'hFFFFFFA5);
    run(32'h101, 0, 2'b00, 0, 32'h0);
    check("ubyte_load", last_rdata, 32'h000000A5);
    run(32'h102, 1, 2'b01, 0, 32'h00008001);
    check("half_store_ram", ram[12'h40], 32'h8001A544);
    run(32'h102, 0, 2'b01, 1, 32'h0);
    check("shalf_load", last_rdata, 32'hFFFF8001);
    run(32'h100, 0, 2'b01, 0, 32'h0);
    check("uhalf_load", last_rdata, 32'h0000A544);

    // Error cases.
    run(32'h102, 1, 2'b10, 0, 32'hCAFEF00D);
    check("err_word_mis", {31'b0, last_err}, 32'h1);
    check("err_word_mis_rd", last_rdata, 32'h0);
    run(32'h101, 0, 2'b01, 0, 32'h0);
    check("err_half_mis", {31'b0, last_err}, 32'h1);
    check("err_half_mis_rd", last_rdata, 32'h0);
    run(32'h100, 1, 2'b11, 0, 32'h12345678);
    check("err_size", {31'b0, last_err}, 32'h1);
    run(32'h4000, 0, 2'b10, 0, 32'h0);
    check("err_range", {31'b0, last_err}, 32'h1);
    check("err_range_rd", last_rdata, 32'h0);
    check("err_ram_intact", ram[12'h40], 32'h8001A544);

    // Backpressure: response held for five cycles.
    ready_mode = 2;
    issue(32'h100, 0, 2'b10, 0, 32'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    v0 = rsp_rdata;
    e0 = rsp_err;
    check("hold_data", v0, 32'h8001A544);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid}, 32'h1);
      check("hold_rdata", rsp_rdata, v0);
      check("hold_err", {31'b0, rsp_err}, {31'b0, e0});
      check("hold_req_ready", {31'b0, req_ready}, 32'h0);
    end
    ready_mode = 0;
    drain();

    // Back-to-back throughput.
    for (int i = 0; i < 4; i++) begin
      issue(32'h100, 0, 2'b10, 0, 32'h0);
      acc[i] = acc_cyc;
    end
    drain();
    for (int i = 1; i < 4; i++) check("b2b_period", acc[i] - acc[i-1], 32'd3);

    // Reset during the ACCESS cycle of a store.
    run(32'h200, 1, 2'b10, 0, 32'h5555AAAA);
    issue(32'h200, 1, 2'b10, 0, 32'h0BADF00D, 1);
    check("abort_we_before", {31'b0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_we_drop", {31'b0, mem_we}, 32'h0);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    #2;
    rst_n  = 1'b1;
    busy   = 0;
    we_cyc = -1;
    exp_q.delete();
    chk_en = 1;
    #1;
    check("abort_req_ready", {31'b0, req_ready}, 32'h1);
    check("abort_ram", ram[12'h80], 32'h5555AAAA);
    run(32'h200, 0, 2'b10, 0, 32'h0);
    check("abort_reload", last_rdata, 32'h5555AAAA);

    // Randomized traffic with random response backpressure.
    ready_mode = 1;
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      case ($urandom % 10)
        0:       a = 32'h4000 + ($urandom % 64);
        1:       a = 32'hFFFFFFFC - ($urandom % 8);
        default: a = $urandom % 64;
      endcase
      issue(a, 1'($urandom), 2'($urandom), 1'($urandom), $urandom);
    end
    drain();
    ready_mode = 0;

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("final_ram_words_differing", bad, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
